// File: rtl/seq_alu.sv
// Registered ALU with N/Z/C/V flags and an iterative shift-add multiplier.
// Single-cycle ops complete at the accepting edge; MUL occupies the block for WIDTH cycles.
module seq_alu #(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_PASSB = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLTU  = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Handshake: an operation is taken on a rising edge where in_valid and in_ready
    // are both high; A, B and alu_op are only sampled at that edge.
    logic accept;
    logic start_mul;
    logic mul_last;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_e;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   diff;
    logic [SHW-1:0]     sh;

    assign accept    = in_valid & in_ready;
    assign start_mul = accept & (alu_op == OP_MUL);
    assign mul_last  = (state == S_MUL) && (cnt == SHW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start_mul) state_next = S_MUL;
            S_MUL:  if (mul_last)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state == S_IDLE) & ~rst;
    end

    // The final partial product is folded in combinationally so the product is
    // registered on the WIDTH-th MUL cycle.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start_mul) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            cnt    <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign sum_ext = {1'b0, A} + {1'b0, B};
    assign diff    = A - B;
    assign sh      = B[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_c   = (A < B);
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:   alu_res = A & B;
            OP_OR:    alu_res = A | B;
            OP_PASSB: alu_res = B;
            OP_XOR:   alu_res = A ^ B;
            OP_SLL:   alu_res = A << sh;
            OP_SRL:   alu_res = A >> sh;
            OP_SRA:   alu_res = $unsigned($signed(A) >>> sh);
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_MUL:   alu_res = '0;
            default:  alu_e   = 1'b1;
        endcase
    end

    // Result and flags hold between completions; zero/negative track the stored result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !start_mul) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
                negative  <= alu_res[WIDTH-1];
                carry     <= alu_c;
                overflow  <= alu_v;
                err       <= alu_e;
            end else if (mul_last) begin
                out_valid <= 1'b1;
                result    <= acc_next[WIDTH-1:0];
                zero      <= (acc_next[WIDTH-1:0] == '0);
                negative  <= acc_next[WIDTH-1];
                carry     <= |acc_next[2*WIDTH-1:WIDTH];
                overflow  <= 1'b0;
                err       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: arithmetic reference model plus a per-cycle compare
// process, with literal expectations for the headline vectors.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic [3:0]  op_in = '0;
    logic        out_valid;
    logic [63:0] result;
    logic        zero, negative, carry, overflow, err;

    logic        v8 = 1'b0;
    logic        rdy8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [3:0]  op8 = '0;
    logic        ov8;
    logic [7:0]  res8;
    logic        z8, n8, c8, vf8, e8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] res;
        logic z, n, c, v, e;
        bit   is_mul;
        int   acc_cyc;
        int   due;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;

    seq_alu #(.WIDTH(64), .SHW(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .alu_op(op_in), .out_valid(out_valid),
        .result(result), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .err(err)
    );

    seq_alu #(.WIDTH(8), .SHW(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
        .A(a8), .B(b8), .alu_op(op8), .out_valid(ov8),
        .result(res8), .zero(z8), .negative(n8), .carry(c8),
        .overflow(vf8), .err(e8)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: results from plain arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t r;
        logic [64:0]        wide;
        logic [127:0]       prod;
        logic signed [65:0] sa, sb, s;
        logic signed [65:0] maxv, minv;
        int sh;
        sa = $signed(a);
        sb = $signed(b);
        maxv = 66'sd9223372036854775807;
        minv = -66'sd9223372036854775808;
        sh = int'(b[5:0]);
        r = '{default: '0};
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r.res = wide[63:0];
                r.c = wide[64];
                s = sa + sb;
                r.v = (s > maxv) || (s < minv);
            end
            4'd1: begin
                r.res = a - b;
                r.c = (a < b);
                s = sa - sb;
                r.v = (s > maxv) || (s < minv);
            end
            4'd2: r.res = a & b;
            4'd3: r.res = a | b;
            4'd4: r.res = b;
            4'd5: r.res = a ^ b;
            4'd6: r.res = a << sh;
            4'd7: r.res = a >> sh;
            4'd8: begin
                r.res = a;
                for (int i = 0; i < sh; i++) r.res = {r.res[63], r.res[63:1]};
            end
            4'd9:  r.res = (sa < sb) ? 64'd1 : 64'd0;
            4'd10: r.res = (a < b) ? 64'd1 : 64'd0;
            4'd11: begin
                prod = {64'd0, a} * {64'd0, b};
                r.res = prod[63:0];
                r.c = (prod[127:64] != 0);
                r.is_mul = 1'b1;
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 0);
        r.n = r.res[63];
        return r;
    endfunction

    // scoreboard compare, every negedge
    always @(negedge clk) begin
        bit hit, busy;
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            errors++;
            $display("FAIL stale_expect: completion due at cycle %0d never seen (cycle %0d)", exp_q[0].due, cyc);
            void'(exp_q.pop_front());
        end
        hit = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        busy = 1'b0;
        foreach (exp_q[i])
            if (exp_q[i].is_mul && exp_q[i].acc_cyc <= cyc && exp_q[i].due > cyc) busy = 1'b1;
        chk("in_ready", in_ready, {63'd0, !rst && !busy});
        chk("out_valid", out_valid, {63'd0, hit});
        if (hit) held = exp_q.pop_front();
        chk("result", result, held.res);
        chk("zero", zero, held.z);
        chk("negative", negative, held.n);
        chk("carry", carry, held.c);
        chk("overflow", overflow, held.v);
        chk("err", err, held.e);
    end

    // driver tasks
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue_ready_timeout", in_ready, 64'd1);
        in_valid = 1'b1;
        op_in = op;
        a_in = a;
        b_in = b;
        e = model(op, a, b);
        e.acc_cyc = cyc + 1;
        e.due = cyc + 1 + ((op == 4'd11) ? 64 : 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
        op_in = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", out_valid, 64'd1);
    endtask

    initial begin
        int n;
        held = '{default: '0};
        #1 rst = 1'b1;
        #2;
        chk("rst_result", result, 64'd0);
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_in_ready", in_ready, 64'd0);
        chk("rst_zero", zero, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        issue(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_ovf_res", result, 64'h8000_0000_0000_0000);
        chk("add_ovf_vcn", {61'd0, overflow, carry, negative}, 64'b101);
        chk("add_ovf_valid", out_valid, 64'd1);

        issue(4'd1, 64'd5, 64'd7);
        chk("sub_neg_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_neg_cnv", {61'd0, carry, negative, overflow}, 64'b110);

        issue(4'd1, 64'd9, 64'd9);
        chk("sub_zero_zc", {62'd0, zero, carry}, 64'b10);

        issue(4'd2, 64'hF0F0, 64'h0FF0);
        chk("b2b_and", result, 64'h00F0);
        issue(4'd3, 64'hF0F0, 64'h0FF0);
        chk("b2b_or", result, 64'hFFF0);
        issue(4'd5, 64'hF0F0, 64'h0FF0);
        chk("b2b_xor", result, 64'hFF00);
        issue(4'd8, 64'h8000_0000_0000_0000, 64'd4);
        chk("b2b_sra", result, 64'hF800_0000_0000_0000);
        chk("b2b_sra_valid", out_valid, 64'd1);

        issue(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_carry_zc", {62'd0, zero, carry}, 64'b11);
        issue(4'd1, 64'h8000_0000_0000_0000, 64'd1);
        chk("sub_ovf_v", overflow, 64'd1);
        issue(4'd6, 64'd1, 64'h1_0000_0043);
        chk("sll_upper_ignored", result, 64'd8);
        issue(4'd7, 64'h8000_0000_0000_0000, 64'd63);
        chk("srl_63", result, 64'd1);
        issue(4'd6, 64'h1234_5678_9ABC_DEF0, 64'h40);
        chk("sll_by0", result, 64'h1234_5678_9ABC_DEF0);
        issue(4'd4, 64'd3, 64'hDEAD);
        chk("passb", result, 64'hDEAD);

        issue(4'd11, 64'hFFFF_FFFF, 64'h1_0000_0001);
        wait_ov(n);
        chk("mul_latency", n, 64'd65);
        chk("mul1_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mul1_carry", carry, 64'd0);

        issue(4'd11, 64'h8000_0000_0000_0000, 64'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op_in = 4'd0;
            a_in = 64'd1;
            b_in = 64'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov(n);
        chk("mul2_zc", {62'd0, zero, carry}, 64'b11);
        chk("mul2_res", result, 64'd0);

        issue(4'd0, 64'd1, 64'd2);
        chk("add_pre_rst", result, 64'd3);
        issue(4'd11, 64'd3, 64'd5);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        held = '{default: '0};
        #1;
        chk("midmul_rst_result", result, 64'd0);
        chk("midmul_rst_ready", in_ready, 64'd0);
        chk("midmul_rst_valid", out_valid, 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        issue(4'd0, 64'd1, 64'd1);
        chk("add_after_rst", result, 64'd2);

        issue(4'd13, 64'd7, 64'd9);
        chk("illegal_res", result, 64'd0);
        chk("illegal_ez", {62'd0, err, zero}, 64'b11);
        issue(4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("slt", result, 64'd1);
        chk("slt_err_clear", err, 64'd0);
        issue(4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("sltu", result, 64'd0);

        @(negedge clk);
        v8 = 1'b1;
        op8 = 4'd11;
        a8 = 8'd16;
        b8 = 8'd16;
        @(posedge clk);
        #1 v8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mul8_latency", n, 64'd9);
        chk("mul8_res", res8, 64'd0);
        chk("mul8_cz", {62'd0, c8, z8}, 64'b11);

        repeat (3) @(negedge clk);
        chk("drain", exp_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
